// File: rtl/uart_pkg.sv
// Shared types for the UART transmit arbiter.
// FSM encoding, source ids and byte width.
package uart_pkg;

    localparam int BYTE_W = 8;

    localparam logic SRC_HOST = 1'b0;
    localparam logic SRC_ECHO = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LAUNCH,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small byte FIFO with occupancy count.
// A push on a full FIFO is accepted only if a pop happens in the same cycle.
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_data,
    input  logic              i_pop,
    output logic [BYTE_W-1:0] o_data,
    output logic              o_full,
    output logic              o_empty,
    output logic [CW-1:0]     o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [BYTE_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wptr;
    logic [AW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;
    logic              w_do_push;
    logic              w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_data    = r_mem[r_rptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler of host FIFO bytes and RX echo bytes
// onto a single UART transmitter with a valid/busy handshake.
module uart_tx_arb
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int BUSY_WAIT  = 3
) (
    input  logic              LPC_CLK,
    input  logic              LPC_RST,
    input  logic [BYTE_W-1:0] host_data,
    input  logic              host_valid,
    input  logic [BYTE_W-1:0] echo_data,
    input  logic              echo_valid,
    input  logic              echo_en,
    input  logic              ovf_clr,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_busy,
    output logic              host_full,
    output logic              host_overflow,
    output logic              echo_drop
);

    localparam int FCW   = $clog2(FIFO_DEPTH) + 1;
    localparam int CNT_W = $clog2(BUSY_WAIT + 1);

    tx_state_t         r_state;
    tx_state_t         w_state_nxt;
    logic [CNT_W-1:0]  r_wait_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_rr;
    logic [BYTE_W-1:0] r_tx_data;
    logic              r_echo_full;
    logic [BYTE_W-1:0] r_echo_data;
    logic              r_echo_drop;
    logic              r_overflow;

    logic [BYTE_W-1:0] w_fifo_data;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [FCW-1:0]    w_fifo_count;
    logic              w_host_pend;
    logic              w_echo_pend;
    logic              w_pick_echo;
    logic              w_grant;
    logic              w_tx_valid;
    logic              w_pop_host;
    logic              w_pop_echo;
    logic              w_host_drop;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (FCW)
    ) u_fifo (
        .i_clk   (LPC_CLK),
        .i_rst_n (LPC_RST),
        .i_push  (host_valid),
        .i_data  (host_data),
        .i_pop   (w_pop_host),
        .o_data  (w_fifo_data),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign w_host_pend = !w_fifo_empty;
    assign w_echo_pend = r_echo_full;
    // Echo wins when alone, or when host was granted last.
    assign w_pick_echo = w_echo_pend && (!w_host_pend || (r_rr == SRC_HOST));
    assign w_pop_host  = w_grant && !w_pick_echo;
    assign w_pop_echo  = w_grant && w_pick_echo;
    assign w_host_drop = host_valid && w_fifo_full && !w_pop_host;

    assign host_full     = (w_fifo_count == FCW'(FIFO_DEPTH));
    assign host_overflow = r_overflow;
    assign echo_drop     = r_echo_drop;
    assign tx_data       = r_tx_data;
    assign tx_valid      = w_tx_valid;

    // Next-state, grant and launch strobe decode.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_grant     = 1'b0;
        w_tx_valid  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!tx_busy && (w_host_pend || w_echo_pend)) begin
                    w_grant     = 1'b1;
                    w_state_nxt = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                w_tx_valid  = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (tx_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_wait_cnt == CNT_W'(BUSY_WAIT - 1)) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_wait_cnt + 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (!tx_busy) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State, rr pointer and the byte handed to the transmitter.
    always_ff @(posedge LPC_CLK) begin
        if (!LPC_RST) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= '0;
            r_rr       <= SRC_HOST;
            r_tx_data  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
            if (w_grant) begin
                r_rr      <= w_pick_echo ? SRC_ECHO : SRC_HOST;
                r_tx_data <= w_pick_echo ? r_echo_data : w_fifo_data;
            end
        end
    end

    // One-entry echo holding register with drop pulse.
    always_ff @(posedge LPC_CLK) begin
        if (!LPC_RST) begin
            r_echo_full <= 1'b0;
            r_echo_data <= '0;
            r_echo_drop <= 1'b0;
        end else begin
            r_echo_drop <= 1'b0;
            if (!echo_en) begin
                r_echo_full <= 1'b0;
            end else if (echo_valid) begin
                if (!r_echo_full || w_pop_echo) begin
                    r_echo_full <= 1'b1;
                    r_echo_data <= echo_data;
                end else begin
                    r_echo_drop <= 1'b1;
                end
            end else if (w_pop_echo) begin
                r_echo_full <= 1'b0;
            end
        end
    end

    // Sticky host overflow; a new drop beats a clear.
    always_ff @(posedge LPC_CLK) begin
        if (!LPC_RST) begin
            r_overflow <= 1'b0;
        end else if (w_host_drop) begin
            r_overflow <= 1'b1;
        end else if (ovf_clr) begin
            r_overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb with a simple
// transmitter model and a queue-based reference of send order.
module tb_uart_tx_arb;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] host_data, echo_data, tx_data;
    logic       host_valid, echo_valid, echo_en, ovf_clr;
    logic       tx_valid, tx_busy;
    logic       host_full, host_overflow, echo_drop;

    int n_cmp = 0;
    int n_bad = 0;

    bit force_busy = 1'b0;
    bit model_on   = 1'b1;
    int busy_len   = 10;
    int busy_cnt   = 0;
    int cyc        = 0;
    int drop_cnt   = 0;
    logic [7:0] sent_q[$];
    int         sent_cyc[$];

    always #5 clk = ~clk;

    uart_tx_arb #(.FIFO_DEPTH(4), .BUSY_WAIT(3)) dut (
        .LPC_CLK       (clk),
        .LPC_RST       (rst_n),
        .host_data     (host_data),
        .host_valid    (host_valid),
        .echo_data     (echo_data),
        .echo_valid    (echo_valid),
        .echo_en       (echo_en),
        .ovf_clr       (ovf_clr),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_busy       (tx_busy),
        .host_full     (host_full),
        .host_overflow (host_overflow),
        .echo_drop     (echo_drop)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Transmitter model: busy for busy_len cycles after each launch.
    always @(posedge clk) begin
        if (!rst_n) busy_cnt <= 0;
        else if (tx_valid && model_on) busy_cnt <= busy_len;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt > 0);

    // Record launches and drop pulses mid-cycle.
    always @(negedge clk) begin
        if (tx_valid) begin
            sent_q.push_back(tx_data);
            sent_cyc.push_back(cyc);
        end
        if (echo_drop) drop_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        repeat (25) tick();
    endtask

    task automatic clear_log();
        sent_q.delete();
        sent_cyc.delete();
        drop_cnt = 0;
    endtask

    task automatic push_host(input logic [7:0] b);
        host_data  = b;
        host_valid = 1'b1;
        tick();
        host_valid = 1'b0;
    endtask

    task automatic push_echo(input logic [7:0] b);
        echo_data  = b;
        echo_valid = 1'b1;
        tick();
        echo_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        clear_log();
    endtask

    task automatic wait_sent(input int n, input int lim, output bit ok);
        for (int i = 0; i < lim; i++) begin
            if (sent_q.size() >= n) break;
            tick();
        end
        ok = (sent_q.size() >= n);
    endtask

    task automatic test_reset();
        bit ok;
        force_busy = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_tx_valid: got %b want 0", tx_valid);
        end
        n_cmp++;
        if (tx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_tx_data: got %h want 00", tx_data);
        end
        n_cmp++;
        if ({host_full, host_overflow, echo_drop} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_flags: got %b want 000",
                     {host_full, host_overflow, echo_drop});
        end
        rst_n = 1'b1;
        clear_log();
        push_host(8'h3C);
        repeat (10) tick();
        n_cmp++;
        if (sent_q.size() != 0) begin
            n_bad++;
            $display("FAIL busy_hold: got %0d sends want 0", sent_q.size());
        end
        force_busy = 1'b0;
        wait_sent(1, 20, ok);
        n_cmp++;
        if (!ok || sent_q[0] !== 8'h3C) begin
            n_bad++;
            $display("FAIL busy_release: got %0d sends want 1 byte 3c", sent_q.size());
        end
    endtask

    task automatic test_single();
        bit ok;
        int n0;
        settle();
        clear_log();
        busy_len = 10;
        host_data  = 8'h41;
        host_valid = 1'b1;
        n0 = cyc;
        tick();
        host_valid = 1'b0;
        wait_sent(1, 10, ok);
        n_cmp++;
        if (!ok || sent_cyc[0] != n0 + 2) begin
            n_bad++;
            $display("FAIL single_latency: got ok=%0d cyc=%0d want cyc %0d",
                     ok, ok ? sent_cyc[0] : -1, n0 + 2);
        end
        n_cmp++;
        if (!ok || sent_q[0] !== 8'h41) begin
            n_bad++;
            $display("FAIL single_data: got %h want 41", ok ? sent_q[0] : 8'hxx);
        end
        repeat (20) tick();
        n_cmp++;
        if (sent_q.size() != 1) begin
            n_bad++;
            $display("FAIL single_count: got %0d strobes want 1", sent_q.size());
        end
        n_cmp++;
        if (dut.r_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL single_idle: got state %0d want IDLE", dut.r_state);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        logic [7:0] exp[5] = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hF5};
        settle();
        clear_log();
        busy_len   = 3;
        force_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            push_host(8'(i));
            if (i == 4) begin
                n_cmp++;
                if (host_full !== 1'b1 || host_overflow !== 1'b0) begin
                    n_bad++;
                    $display("FAIL ovf_full4: got full=%b ovf=%b want 1 0",
                             host_full, host_overflow);
                end
            end
        end
        n_cmp++;
        if (host_overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_set: got %b want 1", host_overflow);
        end
        ovf_clr = 1'b1;
        push_host(8'h66);
        ovf_clr = 1'b0;
        n_cmp++;
        if (host_overflow !== 1'b1) begin
            n_bad++;
            $display("FAIL ovf_clr_vs_set: got %b want 1", host_overflow);
        end
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        n_cmp++;
        if (host_overflow !== 1'b0) begin
            n_bad++;
            $display("FAIL ovf_clear: got %b want 0", host_overflow);
        end
        force_busy = 1'b0;
        push_host(8'hF5);
        n_cmp++;
        if (host_overflow !== 1'b0 || host_full !== 1'b1) begin
            n_bad++;
            $display("FAIL full_push_pop: got ovf=%b full=%b want 0 1",
                     host_overflow, host_full);
        end
        wait_sent(5, 200, ok);
        repeat (15) tick();
        n_cmp++;
        if (!ok || sent_q.size() != 5) begin
            n_bad++;
            $display("FAIL ovf_drain_count: got %0d want 5", sent_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++;
                if (sent_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL ovf_order[%0d]: got %h want %h", i, sent_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_rr();
        bit ok;
        logic [7:0] exp[3] = '{8'hE0, 8'hA0, 8'hA1};
        do_reset();
        busy_len   = 4;
        force_busy = 1'b1;
        echo_en    = 1'b1;
        push_host(8'hA0);
        push_host(8'hA1);
        push_echo(8'hE0);
        tick();
        force_busy = 1'b0;
        wait_sent(3, 100, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL rr_count: got %0d want 3", sent_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (sent_q[i] !== exp[i]) begin
                    n_bad++;
                    $display("FAIL rr_order[%0d]: got %h want %h", i, sent_q[i], exp[i]);
                end
            end
        end
    endtask

    task automatic test_echo();
        bit ok;
        settle();
        clear_log();
        echo_en = 1'b0;
        push_echo(8'h55);
        repeat (15) tick();
        n_cmp++;
        if (sent_q.size() != 0 || drop_cnt != 0) begin
            n_bad++;
            $display("FAIL echo_disabled: got sends=%0d drops=%0d want 0 0",
                     sent_q.size(), drop_cnt);
        end
        echo_en    = 1'b1;
        force_busy = 1'b1;
        push_echo(8'h11);
        push_echo(8'h22);
        repeat (3) tick();
        n_cmp++;
        if (drop_cnt != 1) begin
            n_bad++;
            $display("FAIL echo_drop: got %0d pulses want 1", drop_cnt);
        end
        force_busy = 1'b0;
        wait_sent(1, 20, ok);
        repeat (20) tick();
        n_cmp++;
        if (!ok || sent_q.size() != 1 || sent_q[0] !== 8'h11) begin
            n_bad++;
            $display("FAIL echo_sent: got %0d sends want one byte 11", sent_q.size());
        end
    endtask

    task automatic test_no_busy();
        bit ok;
        int n0;
        settle();
        clear_log();
        model_on = 1'b0;
        n0 = cyc;
        push_host(8'hC1);
        push_host(8'hC2);
        wait_sent(2, 40, ok);
        n_cmp++;
        if (!ok || sent_cyc[0] != n0 + 2 || sent_cyc[1] - sent_cyc[0] != 5) begin
            n_bad++;
            $display("FAIL nobusy_timing: got ok=%0d cyc %0d,%0d want %0d,%0d",
                     ok, ok ? sent_cyc[0] : -1, ok ? sent_cyc[1] : -1,
                     n0 + 2, n0 + 7);
        end
        n_cmp++;
        if (!ok || sent_q[0] !== 8'hC1 || sent_q[1] !== 8'hC2) begin
            n_bad++;
            $display("FAIL nobusy_data: got %0d sends want c1 c2", sent_q.size());
        end
        model_on = 1'b1;
    endtask

    task automatic test_reset_mid();
        bit ok;
        settle();
        clear_log();
        busy_len = 20;
        for (int i = 0; i < 4; i++) push_host(8'h91 + 8'(i));
        n_cmp++;
        if (dut.r_state !== ST_WAIT_DONE) begin
            n_bad++;
            $display("FAIL mid_state: got %0d want WAIT_DONE", dut.r_state);
        end
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if ({tx_valid, host_full, host_overflow, echo_drop} !== 4'b0000
            || tx_data !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_reset: got v/f/o/d=%b data=%h want 0000 00",
                     {tx_valid, host_full, host_overflow, echo_drop}, tx_data);
        end
        rst_n = 1'b1;
        clear_log();
        busy_len = 4;
        repeat (40) tick();
        n_cmp++;
        if (sent_q.size() != 0) begin
            n_bad++;
            $display("FAIL mid_flushed: got %0d sends want 0", sent_q.size());
        end
        push_host(8'h77);
        wait_sent(1, 20, ok);
        n_cmp++;
        if (!ok || sent_q[0] !== 8'h77) begin
            n_bad++;
            $display("FAIL mid_new: got %0d sends want byte 77", sent_q.size());
        end
    endtask

    task automatic test_random();
        bit ok;
        int nh;
        bit en, has_e;
        bit last_echo;
        logic [7:0] hq[$];
        logic [7:0] eb;
        logic [7:0] exp[$];
        bit e_pend;
        do_reset();
        last_echo = 1'b0;
        for (int r = 0; r < 8; r++) begin
            settle();
            clear_log();
            hq.delete();
            exp.delete();
            force_busy = 1'b1;
            nh = $urandom_range(0, 4);
            for (int i = 0; i < nh; i++) begin
                eb = 8'($urandom);
                hq.push_back(eb);
                push_host(eb);
            end
            en      = 1'($urandom_range(0, 1));
            has_e   = 1'($urandom_range(0, 1));
            echo_en = en;
            eb      = 8'($urandom);
            if (has_e) push_echo(eb);
            tick();
            e_pend = en && has_e;
            while (e_pend || hq.size() > 0) begin
                if (e_pend && (hq.size() == 0 || !last_echo)) begin
                    exp.push_back(eb);
                    e_pend    = 1'b0;
                    last_echo = 1'b1;
                end else begin
                    exp.push_back(hq.pop_front());
                    last_echo = 1'b0;
                end
            end
            busy_len   = $urandom_range(1, 6);
            force_busy = 1'b0;
            wait_sent(exp.size(), 150, ok);
            repeat (15) tick();
            n_cmp++;
            if (!ok || sent_q.size() != exp.size()) begin
                n_bad++;
                $display("FAIL rand%0d_count: got %0d want %0d",
                         r, sent_q.size(), exp.size());
            end else begin
                for (int i = 0; i < exp.size(); i++) begin
                    n_cmp++;
                    if (sent_q[i] !== exp[i]) begin
                        n_bad++;
                        $display("FAIL rand%0d_byte[%0d]: got %h want %h",
                                 r, i, sent_q[i], exp[i]);
                    end
                end
            end
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        host_data  = 8'h00;
        host_valid = 1'b0;
        echo_data  = 8'h00;
        echo_valid = 1'b0;
        echo_en    = 1'b1;
        ovf_clr    = 1'b0;
        test_reset();
        test_single();
        test_overflow();
        test_rr();
        test_echo();
        test_no_busy();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
